// File: rtl/naive_bus_arb_pkg.sv
// Shared types and constants for the two-master naive_bus arbiter.
package naive_bus_arb_pkg;
  typedef enum logic {OWN_M0, OWN_M1} arb_owner_t;
  localparam int DEFAULT_MAX_WAIT = 4;
  localparam int STARVE_W = 4;
endpackage

// File: rtl/naive_bus.sv
// naive_bus: request/grant read and write channels; rd_data is valid one cycle after rd_gnt.
// Valid/ready: a transfer happens in the cycle where req and gnt are both high.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, wr_gnt
  );
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/naive_bus_arb_starve_cnt.sv
// Saturating aging counter: counts cycles m0 requests but loses, forces m0 to win at MAX_WAIT.
module naive_bus_arb_starve_cnt
  import naive_bus_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                win,
  input  logic                gnt,
  output logic                force_m0,
  output logic [STARVE_W-1:0] cnt
);
  localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(MAX_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!req || gnt) begin
      cnt <= '0;
    end else if (!win && (cnt != MAX_CNT)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_m0 = (cnt == MAX_CNT);
endmodule

// File: rtl/naive_bus_arbiter.sv
// Two-master naive_bus arbiter: m1 fixed priority with m0 aging guard, lock across slave stalls.
// Optional performance counters enabled by defining NAIVE_BUS_ARB_PERF_EN.
module naive_bus_arbiter
  import naive_bus_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic           clk,
  input  logic           rst,
  naive_bus.slave        m0,
  naive_bus.slave        m1,
  naive_bus.master       s,
  output logic [31:0]    o_conflict_cnt,
  output logic [31:0]    o_m0_wait_cnt
);
  logic                req0, req1, lock, lock_act, force_m0;
  logic                win_m0, win_req, s_rd_gnt, s_wr_gnt, s_gnt, m0_gnt, rd_pending;
  logic [STARVE_W-1:0] starve_cnt;
  arb_owner_t          lock_owner, winner, rd_owner;

  assign req0 = m0.rd_req | m0.wr_req;
  assign req1 = m1.rd_req | m1.wr_req;

  // A lock whose owner has already dropped its request no longer steers the mux.
  assign lock_act = lock & ((lock_owner == OWN_M0) ? req0 : req1);

  always_comb begin
    winner = OWN_M1;
    if (lock_act)              winner = lock_owner;
    else if (req0 && !req1)    winner = OWN_M0;
    else if (req1 && !req0)    winner = OWN_M1;
    else if (req0 && force_m0) winner = OWN_M0;
  end

  assign win_m0  = (winner == OWN_M0);
  assign win_req = win_m0 ? req0 : req1;

  always_comb begin
    s.rd_req  = 1'b0;
    s.rd_addr = '0;
    s.wr_req  = 1'b0;
    s.wr_addr = '0;
    s.wr_data = '0;
    s.wr_be   = '0;
    if (win_req) begin
      s.rd_req  = win_m0 ? m0.rd_req  : m1.rd_req;
      s.rd_addr = win_m0 ? m0.rd_addr : m1.rd_addr;
      s.wr_req  = win_m0 ? m0.wr_req  : m1.wr_req;
      s.wr_addr = win_m0 ? m0.wr_addr : m1.wr_addr;
      s.wr_data = win_m0 ? m0.wr_data : m1.wr_data;
      s.wr_be   = win_m0 ? m0.wr_be   : m1.wr_be;
    end
  end

  assign s_rd_gnt  = s.rd_gnt & win_req;
  assign s_wr_gnt  = s.wr_gnt & win_req;
  assign s_gnt     = s_rd_gnt | s_wr_gnt;
  assign m0.rd_gnt = s_rd_gnt & win_m0;
  assign m0.wr_gnt = s_wr_gnt & win_m0;
  assign m1.rd_gnt = s_rd_gnt & !win_m0;
  assign m1.wr_gnt = s_wr_gnt & !win_m0;
  assign m0_gnt    = m0.rd_gnt | m0.wr_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock       <= 1'b0;
      lock_owner <= OWN_M0;
      rd_pending <= 1'b0;
      rd_owner   <= OWN_M0;
    end else begin
      lock <= win_req & !s_gnt;
      if (win_req && !s_gnt) lock_owner <= winner;
      rd_pending <= s_rd_gnt;
      if (s_rd_gnt) rd_owner <= winner;
    end
  end

  assign m0.rd_data = (rd_pending && (rd_owner == OWN_M0)) ? s.rd_data : '0;
  assign m1.rd_data = (rd_pending && (rd_owner == OWN_M1)) ? s.rd_data : '0;

  naive_bus_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .req      (req0),
    .win      (win_m0),
    .gnt      (m0_gnt),
    .force_m0 (force_m0),
    .cnt      (starve_cnt)
  );

`ifdef NAIVE_BUS_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_conflict_cnt <= '0;
      o_m0_wait_cnt  <= '0;
    end else begin
      if (req0 && req1)    o_conflict_cnt <= o_conflict_cnt + 32'd1;
      if (req0 && !m0_gnt) o_m0_wait_cnt  <= o_m0_wait_cnt + 32'd1;
    end
  end
`else
  assign o_conflict_cnt = 32'h0;
  assign o_m0_wait_cnt  = 32'h0;
`endif
endmodule

// File: tb/tb_naive_bus_arbiter.sv
// Directed bench for naive_bus_arbiter with hand-computed expectations.
module tb_naive_bus_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] conflict_cnt, m0_wait_cnt;
  int          checks = 0;
  int          errors = 0;

  naive_bus m0_bus();
  naive_bus m1_bus();
  naive_bus s_bus();

  naive_bus_arbiter #(.MAX_WAIT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .m0             (m0_bus.slave),
    .m1             (m1_bus.slave),
    .s              (s_bus.master),
    .o_conflict_cnt (conflict_cnt),
    .o_m0_wait_cnt  (m0_wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m0_bus.rd_req = 0; m0_bus.rd_addr = 0; m0_bus.wr_req = 0;
    m0_bus.wr_addr = 0; m0_bus.wr_data = 0; m0_bus.wr_be = 0;
    m1_bus.rd_req = 0; m1_bus.rd_addr = 0; m1_bus.wr_req = 0;
    m1_bus.wr_addr = 0; m1_bus.wr_data = 0; m1_bus.wr_be = 0;
    s_bus.rd_gnt = 0; s_bus.wr_gnt = 0; s_bus.rd_data = 0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Slave that grants whatever the arbiter forwards.
  task automatic auto_slave();
    #1;
    s_bus.rd_gnt = s_bus.rd_req;
    s_bus.wr_gnt = s_bus.wr_req;
  endtask

  task automatic dual_req();
    m0_bus.rd_req = 1; m0_bus.rd_addr = 32'hA0;
    m1_bus.wr_req = 1; m1_bus.wr_addr = 32'hB0; m1_bus.wr_data = 32'h55; m1_bus.wr_be = 4'hF;
  endtask

  logic [6:0] exp_m0_win;

  initial begin
    idle();
    settle();
    chk("rst_m0_rd_gnt", m0_bus.rd_gnt, 0);
    chk("rst_m1_wr_gnt", m1_bus.wr_gnt, 0);
    chk("rst_m0_rd_data", m0_bus.rd_data, 0);
    chk("rst_conflict", conflict_cnt, 0);
    next_cyc(); rst = 0;

    // Reset while a read return is pending.
    next_cyc(); m0_bus.rd_req = 1; m0_bus.rd_addr = 32'h100; s_bus.rd_gnt = 1;
    settle(); chk("pre_rst_m0_rd_gnt", m0_bus.rd_gnt, 1);
    next_cyc(); idle(); rst = 1; s_bus.rd_data = 32'hCAFEF00D;
    settle(); chk("rst_mid_m0_rd_data", m0_bus.rd_data, 0);
    next_cyc(); rst = 0; s_bus.rd_data = 32'hCAFEF00D;
    settle();
    chk("post_rst_m0_rd_data", m0_bus.rd_data, 0);
    chk("post_rst_m1_rd_data", m1_bus.rd_data, 0);
    chk("post_rst_m0_rd_gnt", m0_bus.rd_gnt, 0);

    // Solo read by m0.
    next_cyc(); idle(); m0_bus.rd_req = 1; m0_bus.rd_addr = 32'h100; s_bus.rd_gnt = 1;
    settle();
    chk("solo_s_rd_addr", s_bus.rd_addr, 32'h100);
    chk("solo_m0_rd_gnt", m0_bus.rd_gnt, 1);
    chk("solo_m1_rd_gnt", m1_bus.rd_gnt, 0);
    next_cyc(); idle(); s_bus.rd_data = 32'hDEADBEEF;
    settle();
    chk("solo_m0_rd_data", m0_bus.rd_data, 32'hDEADBEEF);
    chk("solo_m1_rd_data", m1_bus.rd_data, 0);
    chk("idle_s_rd_req", s_bus.rd_req, 0);
    chk("idle_s_rd_addr", s_bus.rd_addr, 0);
    next_cyc(); s_bus.rd_data = 32'hDEADBEEF;
    settle(); chk("solo_rd_data_one_shot", m0_bus.rd_data, 0);

    // Contention: m1 write wins, m0 read follows.
    next_cyc(); idle();
    m0_bus.rd_req = 1; m0_bus.rd_addr = 32'h200;
    m1_bus.wr_req = 1; m1_bus.wr_addr = 32'h300; m1_bus.wr_data = 32'h12345678; m1_bus.wr_be = 4'hF;
    s_bus.wr_gnt = 1;
    settle();
    chk("cont_s_wr_req", s_bus.wr_req, 1);
    chk("cont_s_rd_req", s_bus.rd_req, 0);
    chk("cont_s_wr_addr", s_bus.wr_addr, 32'h300);
    chk("cont_s_wr_data", s_bus.wr_data, 32'h12345678);
    chk("cont_s_wr_be", s_bus.wr_be, 4'hF);
    chk("cont_m1_wr_gnt", m1_bus.wr_gnt, 1);
    chk("cont_m0_rd_gnt", m0_bus.rd_gnt, 0);
    next_cyc(); idle(); m0_bus.rd_req = 1; m0_bus.rd_addr = 32'h200; s_bus.rd_gnt = 1;
    settle();
    chk("cont2_s_rd_addr", s_bus.rd_addr, 32'h200);
    chk("cont2_m0_rd_gnt", m0_bus.rd_gnt, 1);
    next_cyc(); idle(); s_bus.rd_data = 32'h0BADF00D;
    settle(); chk("cont_m0_rd_data", m0_bus.rd_data, 32'h0BADF00D);

    // Starvation: m1 wins four times, m0 forced on the fifth cycle.
    exp_m0_win = 7'b0010000;
    for (int i = 0; i < 7; i++) begin
      next_cyc(); idle(); dual_req(); auto_slave();
      settle();
      chk($sformatf("starve_m0_gnt_%0d", i), m0_bus.rd_gnt, exp_m0_win[i]);
      chk($sformatf("starve_m1_gnt_%0d", i), m1_bus.wr_gnt, !exp_m0_win[i]);
    end
    next_cyc(); idle(); settle();

    // Slave stall: m0 holds the bus until granted even though m1 arrives.
    next_cyc(); m0_bus.rd_req = 1; m0_bus.rd_addr = 32'h400;
    settle(); chk("lock_c0_s_rd_addr", s_bus.rd_addr, 32'h400);
    for (int i = 1; i < 3; i++) begin
      next_cyc(); m1_bus.wr_req = 1; m1_bus.wr_addr = 32'h500; m1_bus.wr_data = 32'h77; m1_bus.wr_be = 4'h3;
      settle();
      chk($sformatf("lock_c%0d_s_rd_addr", i), s_bus.rd_addr, 32'h400);
      chk($sformatf("lock_c%0d_s_wr_req", i), s_bus.wr_req, 0);
      chk($sformatf("lock_c%0d_m1_wr_gnt", i), m1_bus.wr_gnt, 0);
    end
    next_cyc(); s_bus.rd_gnt = 1;
    settle();
    chk("lock_c3_m0_rd_gnt", m0_bus.rd_gnt, 1);
    chk("lock_c3_m1_wr_gnt", m1_bus.wr_gnt, 0);
    next_cyc(); m0_bus.rd_req = 0; s_bus.rd_gnt = 0; s_bus.wr_gnt = 1; s_bus.rd_data = 32'h44;
    settle();
    chk("lock_c4_s_wr_addr", s_bus.wr_addr, 32'h500);
    chk("lock_c4_m1_wr_gnt", m1_bus.wr_gnt, 1);
    chk("lock_c4_m0_rd_data", m0_bus.rd_data, 32'h44);
    chk("lock_c4_m1_rd_data", m1_bus.rd_data, 0);

    // Back-to-back reads to alternating masters.
    next_cyc(); idle(); m0_bus.rd_req = 1; m0_bus.rd_addr = 32'h10; s_bus.rd_gnt = 1;
    settle(); chk("b2b_m0_rd_gnt", m0_bus.rd_gnt, 1);
    next_cyc(); idle(); m1_bus.rd_req = 1; m1_bus.rd_addr = 32'h20; s_bus.rd_gnt = 1; s_bus.rd_data = 32'hD0;
    settle();
    chk("b2b_m1_rd_gnt", m1_bus.rd_gnt, 1);
    chk("b2b_m0_rd_data", m0_bus.rd_data, 32'hD0);
    chk("b2b_m1_rd_data0", m1_bus.rd_data, 0);
    next_cyc(); idle(); s_bus.rd_data = 32'hD1;
    settle();
    chk("b2b_m1_rd_data", m1_bus.rd_data, 32'hD1);
    chk("b2b_m0_rd_data0", m0_bus.rd_data, 0);

    // Performance counters over 10 dual-request cycles from a fresh reset.
    next_cyc(); idle(); rst = 1;
    next_cyc(); rst = 0;
    for (int i = 0; i < 10; i++) begin
      next_cyc(); idle(); dual_req(); auto_slave();
    end
    next_cyc(); idle(); settle();
`ifdef NAIVE_BUS_ARB_PERF_EN
    chk("perf_conflict", conflict_cnt, 32'd10);
    chk("perf_m0_wait", m0_wait_cnt, 32'd8);
`else
    chk("perf_conflict_off", conflict_cnt, 32'd0);
    chk("perf_m0_wait_off", m0_wait_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/naive_bus_arbiter.md
Name: naive_bus_arbiter

Overview:
Two-master to one-slave arbiter for naive_bus. It lets the instruction port and the data port of the core share a single memory or peripheral slave, such as a unified RAM. Data master (m1) has fixed priority, with an aging guard so the instruction master (m0) cannot starve. Read data, which arrives one cycle after grant, is routed back to the master that was granted.

Parameters:
MAX_WAIT, 4, consecutive lost-arbitration cycles after which m0 is forced to win (1..15).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
m0  naive_bus.slave  -  instruction-side master port
m1  naive_bus.slave  -  data-side master port
s  naive_bus.master  -  shared downstream slave port
o_conflict_cnt  out  32  cycles with both masters requesting; 0 when feature is off
o_m0_wait_cnt  out  32  cycles m0 requested without grant; 0 when feature is off

Behaviour:
- Bus fields:
  - Read side: rd_req, rd_gnt, rd_addr[31:0], rd_data[31:0]. rd_data is valid the cycle after rd_gnt.
  - Write side: wr_req, wr_gnt, wr_addr, wr_data, wr_be[3:0].
  - A master never asserts rd_req and wr_req together.
- Request of master k = mk.rd_req | mk.wr_req.
- Winner selection is combinational, in priority order:
  - lock held -> lock_owner;
  - only one master requests -> that master;
  - both request and starve_cnt == MAX_WAIT -> m0;
  - both request otherwise -> m1.
- Forwarding (0 added latency):
  - The winner's req, addr, wdata and be drive s.
  - When no master requests, all s outputs are 0.
- Grants:
  - s.rd_gnt and s.wr_gnt go only to the winner.
  - The loser's rd_gnt and wr_gnt are 0.
- Lock:
  - Set at a clock edge where the winner's request is high but the slave did not grant; lock_owner <= winner.
  - Cleared when that master is granted, or drops its request.
  - Keeps addr/wdata stable across slave stalls.
- Read return:
  - On s.rd_gnt, register rd_pending <= 1 and rd_owner <= winner; otherwise rd_pending <= 0.
  - Next cycle, s.rd_data is routed to rd_owner's rd_data. The other master sees 0.
  - Back-to-back reads to alternating masters are supported at full rate.
- starve_cnt (4 bits):
  - Increments when m0 requests and m0 is not the winner.
  - Saturates at MAX_WAIT.
  - Clears when m0 is granted (rd or wr) or m0 is not requesting.
- Reset (asynchronous, rst=1):
  - Cleared: lock=0, lock_owner=m0, rd_pending=0, rd_owner=m0, starve_cnt=0, counters=0.
  - All grants to masters are 0; both masters' rd_data is 0.
- Reset mid-operation: a pending read return is discarded, and rd_data is 0 after release.
- Simultaneous events:
  - A grant and a request withdrawal in the same cycle clear the lock; grant takes precedence.
  - The slave granting while starve_cnt saturates: the counter is judged on the current winner.

Optional Feature:
NAIVE_BUS_ARB_PERF_EN
- Defined: two 32-bit wrapping counters.
  - o_conflict_cnt increments each cycle both masters request.
  - o_m0_wait_cnt increments each cycle m0 requests and m0 receives no grant.
- Undefined: no counter flops; both outputs tied to 32'h0.

Decomposition:
- Package naive_bus_arb_pkg:
  - typedef enum logic {OWN_M0, OWN_M1} arb_owner_t;
  - localparam DEFAULT_MAX_WAIT = 4;
  - starve counter width = 4.
- One sub-module, naive_bus_arb_starve_cnt: saturating aging counter with inputs req, win, gnt and output force_m0.
- Mux and lock logic stay in the top.

Test Plan:
- Reset: assert rst mid-read (s.rd_gnt=1 in the prior cycle) -> after release, m0.rd_data=m1.rd_data=0 and all grants are 0.
- Solo read: m0 reads 0x100, slave grants immediately and returns 0xDEADBEEF -> m0.rd_gnt=1 in cycle 0, m0.rd_data=0xDEADBEEF in cycle 1, m1.rd_data=0.
- Contention: m0 reads 0x200 and m1 writes 0x300/0x12345678 in the same cycle -> s sees the write first; m0 is granted the next cycle.
- Starvation: m0 and m1 request continuously, slave always grants, MAX_WAIT=4 -> m0 granted on cycle 5, then m1 wins again.
- Slave stall lock: m0 alone requests 0x400, slave withholds gnt 3 cycles, m1 requests in cycle 1 -> s.rd_addr stays 0x400 until granted and m1 gets no grant.
- Perf counters (NAIVE_BUS_ARB_PERF_EN defined): 10 cycles of dual requests -> o_conflict_cnt=10. Undefined -> both counters read 0.
